johnson_counter: RTL and testbench

//   Parameterised Johnson (twisted-ring) counter cycling 2*WIDTH states, default 8 bits / 16 states.

---
 rtl/johnson_counter_if.sv | 28 ++
 rtl/johnson_counter.sv | 65 ++++++
 tb/tb_johnson_counter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/johnson_counter_if.sv
// Johnson counter control/status bundle.
// The master drives en/dir; the slave returns state, index and wrap.
interface johnson_counter_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(2*WIDTH)
);
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] out;
  logic [IDX_W-1:0] idx;
  logic             wrap;

  modport master (
    output en,
    output dir,
    input  out,
    input  idx,
    input  wrap
  );

  modport slave (
    input  en,
    input  dir,
    output out,
    output idx,
    output wrap
  );
endinterface

// File: rtl/johnson_counter.sv
// Twisted-ring counter, 2*WIDTH states, with direction,
// illegal-state recovery, binary index and wrap pulse.
module johnson_counter #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] out,
  input  logic             en,
  input  logic             dir,
  output logic [IDX_W-1:0] idx,
  output logic             wrap
);

  logic             step;
  logic             legal;
  logic [WIDTH-1:0] run;
  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] nxt;

  // A floating enable counts; only a clean 0 holds.
  assign step = (en !== 1'b0);

  function automatic logic [IDX_W-1:0] idx_of(
    input logic [WIDTH-1:0] v
  );
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++)
      n += int'(v[i]);
    if (v[WIDTH-1])
      n = 2*WIDTH - n;
    return IDX_W'(n);
  endfunction

  // Legal states fold onto a low-anchored run of ones.
  always_comb begin
    run   = out[WIDTH-1] ? ~out : out;
    legal = ((run & (run + WIDTH'(1))) == '0);
    fwd   = {out[WIDTH-2:0], ~out[WIDTH-1]};
    rev   = {~out[0], out[WIDTH-1:1]};
    nxt   = dir ? rev : fwd;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      out  <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end else if (!step) begin
      wrap <= 1'b0;
    end else if (legal) begin
      out  <= nxt;
      idx  <= idx_of(nxt);
      wrap <= (nxt == '0);
    end else begin
      out  <= '0;
      idx  <= '0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_johnson_counter.sv
// Randomised scoreboard bench for johnson_counter.
// Reference model tracks a sequence position, not shift state.
module tb_johnson_counter;
  localparam int W  = 8;
  localparam int IW = $clog2(2*W);
  localparam int N  = 2*W;

  typedef struct {
    logic [W-1:0]  out;
    logic [IW-1:0] idx;
    logic          wrap;
    bit            chk_idx;
    int            id;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  johnson_counter_if #(.WIDTH(W)) jif ();

  johnson_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .out  (jif.out),
    .en   (jif.en),
    .dir  (jif.dir),
    .idx  (jif.idx),
    .wrap (jif.wrap)
  );

  always #5 clk = ~clk;

  exp_t         q[$];
  int           tests = 0;
  int           fails = 0;
  int           nid   = 0;
  logic [W-1:0] tab[N];
  int           p     = 0;
  bit           ill   = 0;
  bit           stale = 0;
  bit           mwrap = 0;
  logic [W-1:0] raw   = '0;
  logic [W-1:0] inj_val;

  function automatic logic [W-1:0] pat(input int k);
    logic [W-1:0] ones;
    ones = '1;
    if (k <= W)
      return W'((64'd1 << k) - 64'd1);
    return ones & ~W'((64'd1 << (k - W)) - 64'd1);
  endfunction

  task automatic push;
    exp_t e;
    e.out     = ill ? raw : tab[p];
    e.idx     = IW'(p);
    e.wrap    = mwrap;
    e.chk_idx = !stale && !ill;
    e.id      = nid++;
    q.push_back(e);
  endtask

  task automatic model(input bit r, input bit e, input bit d);
    if (r) begin
      p = 0; ill = 0; stale = 0; mwrap = 0;
    end else if (e) begin
      stale = 0;
      if (ill) begin
        p = 0; ill = 0; mwrap = 0;
      end else begin
        p = d ? (p + N - 1) % N : (p + 1) % N;
        mwrap = (p == 0);
      end
    end else begin
      mwrap = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit d);
    @(negedge clk);
    rstn   = r;
    jif.en = e;
    jif.dir = d;
    model(r, e, d);
    push();
  endtask

  task automatic inject(input logic [W-1:0] v);
    int pos;
    @(negedge clk);
    rstn    = 1'b0;
    jif.en  = 1'b0;
    inj_val = v;
    force dut.out = inj_val;
    #1;
    release dut.out;
    pos = -1;
    for (int k = 0; k < N; k++)
      if (tab[k] == v) pos = k;
    if (pos >= 0) begin
      p = pos; ill = 0;
    end else begin
      raw = v; ill = 1;
    end
    stale = 1;
    mwrap = 0;
    push();
  endtask

  task automatic chk(input string nm, input int id,
                     input logic [W-1:0] g, input logic [W-1:0] x);
    tests++;
    if (g !== x) begin
      fails++;
      $display("FAIL %s #%0d got %0h expected %0h", nm, id, g, x);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out", e.id, jif.out, e.out);
        if (e.chk_idx)
          chk("idx", e.id, W'(jif.idx), W'(e.idx));
        chk("wrap", e.id, W'(jif.wrap), W'(e.wrap));
      end
    end
  end

  initial begin
    int bound;
    for (int k = 0; k < N; k++)
      tab[k] = pat(k);
    rstn    = 1'b1;
    jif.en  = 1'b1;
    jif.dir = 1'b0;

    cyc(1, 1, 0);
    repeat (17) cyc(0, 1, 0);

    cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 1);
    cyc(0, 1, 0);

    cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);
    repeat (5) cyc(0, 0, 0);

    inject(8'h55);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);

    repeat (10) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 3)
        inject(W'($urandom));
      else
        cyc($urandom_range(99) < 3,
            $urandom_range(99) < 80,
            1'($urandom));
    end

    bound = 0;
    while (q.size() > 0 && bound < 10) begin
      @(posedge clk);
      bound++;
    end
    #2;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain left %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
